// File: rtl/am_pkg.sv
// Shared constants, FSM state type and width helpers for the multi-head associative memory.
package am_pkg;

    localparam int unsigned AM_HV_DIMENSION = 2000;
    localparam int unsigned AM_CHUNK        = 250;
    localparam int unsigned AM_CLASSES      = 2;
    localparam int unsigned AM_HEADS        = 2;
    localparam int unsigned AM_MODALITIES   = 3;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        OUTPUT
    } amState_t;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(n))) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned maxOne(input int unsigned n);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/am_chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
module am_chunk_popcount
    import am_pkg::*;
#(
    parameter  int unsigned CHUNK   = AM_CHUNK,
    localparam int unsigned COUNT_W = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0]   Bits_DI,
    output logic [COUNT_W-1:0] Count_c
);

    always_comb begin
        Count_c = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            Count_c = Count_c + COUNT_W'(Bits_DI[i]);
        end
    end

endmodule

// File: rtl/associative_memory_multihead.sv
// HD associative memory: majority-fuses the modality hypervectors, then finds the nearest prototype per head.
// Define AM_MARGIN_EN to add per-head second-best tracking and the MarginOut_DO port.
module associative_memory_multihead
    import am_pkg::*;
#(
    parameter  int unsigned HV_DIMENSION = AM_HV_DIMENSION,
    parameter  int unsigned CHUNK        = AM_CHUNK,
    parameter  int unsigned CLASSES      = AM_CLASSES,
    parameter  int unsigned HEADS        = AM_HEADS,
    parameter  int unsigned MODALITIES   = AM_MODALITIES,
    localparam int unsigned DIST_W       = clog2(HV_DIMENSION + 1),
    localparam int unsigned LABEL_W      = maxOne(clog2(CLASSES)),
    localparam int unsigned PROTO_AW     = maxOne(clog2(HEADS * CLASSES))
) (
    input  logic                               Clk_CI,
    input  logic                               Reset_RBI,
    input  logic                               ValidIn_SI,
    output logic                               ReadyOut_SO,
    input  logic [MODALITIES*HV_DIMENSION-1:0] HypervectorIn_DI,
    output logic                               ValidOut_SO,
    input  logic                               ReadyIn_SI,
    output logic [HEADS*LABEL_W-1:0]           LabelOut_DO,
    output logic [HEADS*DIST_W-1:0]            DistanceOut_DO,
    input  logic                               ProtoWrEn_SI,
    input  logic [PROTO_AW-1:0]                ProtoWrAddr_SI,
`ifdef AM_MARGIN_EN
    input  logic [HV_DIMENSION-1:0]            ProtoWrData_DI,
    output logic [HEADS*DIST_W-1:0]            MarginOut_DO
`else
    input  logic [HV_DIMENSION-1:0]            ProtoWrData_DI
`endif
);

    localparam int unsigned NCHUNK   = HV_DIMENSION / CHUNK;
    localparam int unsigned NPROTO   = HEADS * CLASSES;
    localparam int unsigned PC_W     = clog2(CHUNK + 1);
    localparam int unsigned CHUNK_CW = maxOne(clog2(NCHUNK));
    localparam int unsigned MOD_W    = clog2(MODALITIES + 1);

    if ((HV_DIMENSION % CHUNK) != 0) begin : gen_err_chunk
        $error("HV_DIMENSION must be a multiple of CHUNK");
    end
    if ((MODALITIES % 2) == 0) begin : gen_err_modalities
        $error("MODALITIES must be odd");
    end
    if (CLASSES < 2) begin : gen_err_classes
        $error("CLASSES must be at least 2");
    end

    amState_t                  stateQ, stateD;
    logic [CHUNK_CW-1:0]       chunkQ;
    logic [LABEL_W-1:0]        classQ;
    logic [HV_DIMENSION-1:0]   queryQ;
    logic [HV_DIMENSION-1:0]   majority_c;
    logic [HV_DIMENSION-1:0]   protoQ [NPROTO];
    logic [DIST_W-1:0]         chunkBase_c;
    logic                      accept_c;
    logic                      protoWe_c;
    logic                      lastChunk_c;
    logic                      lastClass_c;
    logic                      loadOut_c;

    // Bitwise majority across the modality slices.
    always_comb begin
        logic [MOD_W-1:0] ones;
        majority_c = '0;
        ones       = '0;
        for (int unsigned i = 0; i < HV_DIMENSION; i++) begin
            ones = '0;
            for (int unsigned m = 0; m < MODALITIES; m++) begin
                ones = ones + MOD_W'(HypervectorIn_DI[m*HV_DIMENSION + i]);
            end
            majority_c[i] = (ones > MOD_W'(MODALITIES / 2));
        end
    end

    assign lastChunk_c = (chunkQ == CHUNK_CW'(NCHUNK - 1));
    assign lastClass_c = (classQ == LABEL_W'(CLASSES - 1));
    assign chunkBase_c = DIST_W'(chunkQ) * DIST_W'(CHUNK);

    // Next-state and control strobes.
    always_comb begin
        stateD    = stateQ;
        accept_c  = 1'b0;
        protoWe_c = 1'b0;
        loadOut_c = 1'b0;
        unique case (stateQ)
            IDLE: begin
                accept_c  = ValidIn_SI;
                protoWe_c = ProtoWrEn_SI && !ValidIn_SI && (32'(ProtoWrAddr_SI) < NPROTO);
                if (ValidIn_SI) begin
                    stateD = SEARCH;
                end
            end
            SEARCH: begin
                if (lastChunk_c && lastClass_c) begin
                    stateD = OUTPUT;
                end
            end
            OUTPUT: begin
                loadOut_c = !ValidOut_SO;
                if (ValidOut_SO && ReadyIn_SI) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Query latch, search counters and handshake flags.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            ReadyOut_SO <= 1'b1;
            ValidOut_SO <= 1'b0;
            queryQ      <= '0;
            chunkQ      <= '0;
            classQ      <= '0;
        end else begin
            ReadyOut_SO <= (stateD == IDLE);
            if (accept_c) begin
                queryQ <= majority_c;
                chunkQ <= '0;
                classQ <= '0;
            end else if (stateQ == SEARCH) begin
                if (lastChunk_c) begin
                    chunkQ <= '0;
                    classQ <= lastClass_c ? '0 : classQ + LABEL_W'(1);
                end else begin
                    chunkQ <= chunkQ + CHUNK_CW'(1);
                end
            end
            if (loadOut_c) begin
                ValidOut_SO <= 1'b1;
            end else if (ValidOut_SO && ReadyIn_SI) begin
                ValidOut_SO <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            for (int unsigned p = 0; p < NPROTO; p++) begin
                protoQ[p] <= '0;
            end
        end else if (protoWe_c) begin
            protoQ[ProtoWrAddr_SI] <= ProtoWrData_DI;
        end
    end

    for (genvar h = 0; h < HEADS; h++) begin : gen_head
        logic [PROTO_AW-1:0] protoIdx_c;
        logic [CHUNK-1:0]    diff_c;
        logic [PC_W-1:0]     pc_c;
        logic [DIST_W-1:0]   dist_c;
        logic [DIST_W-1:0]   accQ;
        logic [DIST_W-1:0]   bestQ;
        logic [LABEL_W-1:0]  bestLabelQ;
        logic [DIST_W-1:0]   distOutQ;
        logic [LABEL_W-1:0]  labelOutQ;

        assign protoIdx_c = PROTO_AW'(h * CLASSES) + PROTO_AW'(classQ);
        assign diff_c     = protoQ[protoIdx_c][chunkBase_c +: CHUNK] ^ queryQ[chunkBase_c +: CHUNK];

        am_chunk_popcount #(
            .CHUNK (CHUNK)
        ) u_popcount (
            .Bits_DI (diff_c),
            .Count_c (pc_c)
        );

        assign dist_c = accQ + DIST_W'(pc_c);

`ifdef AM_MARGIN_EN
        logic [DIST_W-1:0] secondQ;
        logic [DIST_W-1:0] marginOutQ;

        always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
            if (!Reset_RBI) begin
                secondQ    <= '0;
                marginOutQ <= '0;
            end else begin
                if (accept_c) begin
                    secondQ <= '1;
                end else if ((stateQ == SEARCH) && lastChunk_c) begin
                    if (dist_c < bestQ) begin
                        secondQ <= bestQ;
                    end else if (dist_c < secondQ) begin
                        secondQ <= dist_c;
                    end
                end
                if (loadOut_c) begin
                    marginOutQ <= secondQ - bestQ;
                end
            end
        end

        assign MarginOut_DO[h*DIST_W +: DIST_W] = marginOutQ;
`endif

        // Chunk accumulation and strict-less best tracking, so ties keep the lower class.
        always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
            if (!Reset_RBI) begin
                accQ       <= '0;
                bestQ      <= '0;
                bestLabelQ <= '0;
                distOutQ   <= '0;
                labelOutQ  <= '0;
            end else begin
                if (accept_c) begin
                    accQ       <= '0;
                    bestQ      <= '1;
                    bestLabelQ <= '0;
                end else if (stateQ == SEARCH) begin
                    if (lastChunk_c) begin
                        accQ <= '0;
                        if (dist_c < bestQ) begin
                            bestQ      <= dist_c;
                            bestLabelQ <= classQ;
                        end
                    end else begin
                        accQ <= dist_c;
                    end
                end
                if (loadOut_c) begin
                    distOutQ  <= bestQ;
                    labelOutQ <= bestLabelQ;
                end
            end
        end

        assign LabelOut_DO[h*LABEL_W +: LABEL_W]   = labelOutQ;
        assign DistanceOut_DO[h*DIST_W +: DIST_W] = distOutQ;
    end

endmodule

// File: tb/tb_associative_memory_multihead.sv
// Directed bench for associative_memory_multihead (D=64, CHUNK=16, CLASSES=4, HEADS=2, MODALITIES=3).
module tb_associative_memory_multihead;

    localparam int unsigned D  = 64;
    localparam int unsigned CH = 16;
    localparam int unsigned CL = 4;
    localparam int unsigned HD = 2;
    localparam int unsigned MO = 3;
    localparam int unsigned DW = 7;
    localparam int unsigned LW = 2;
    localparam int unsigned AW = 3;

    localparam logic [63:0] Q1   = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] Q2   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] M40  = 64'h0000_00FF_FFFF_FFFF;

    logic              Clk_CI = 1'b0;
    logic              Reset_RBI = 1'b0;
    logic              ValidIn_SI = 1'b0;
    logic              ReadyOut_SO;
    logic [MO*D-1:0]   HypervectorIn_DI = '0;
    logic              ValidOut_SO;
    logic              ReadyIn_SI = 1'b0;
    logic [HD*LW-1:0]  LabelOut_DO;
    logic [HD*DW-1:0]  DistanceOut_DO;
    logic              ProtoWrEn_SI = 1'b0;
    logic [AW-1:0]     ProtoWrAddr_SI = '0;
    logic [D-1:0]      ProtoWrData_DI = '0;
`ifdef AM_MARGIN_EN
    logic [HD*DW-1:0]  MarginOut_DO;
`endif

    int total = 0;
    int bad   = 0;

    associative_memory_multihead #(
        .HV_DIMENSION (D),
        .CHUNK        (CH),
        .CLASSES      (CL),
        .HEADS        (HD),
        .MODALITIES   (MO)
    ) dut (
        .Clk_CI           (Clk_CI),
        .Reset_RBI        (Reset_RBI),
        .ValidIn_SI       (ValidIn_SI),
        .ReadyOut_SO      (ReadyOut_SO),
        .HypervectorIn_DI (HypervectorIn_DI),
        .ValidOut_SO      (ValidOut_SO),
        .ReadyIn_SI       (ReadyIn_SI),
        .LabelOut_DO      (LabelOut_DO),
        .DistanceOut_DO   (DistanceOut_DO),
        .ProtoWrEn_SI     (ProtoWrEn_SI),
        .ProtoWrAddr_SI   (ProtoWrAddr_SI),
`ifdef AM_MARGIN_EN
        .ProtoWrData_DI   (ProtoWrData_DI),
        .MarginOut_DO     (MarginOut_DO)
`else
        .ProtoWrData_DI   (ProtoWrData_DI)
`endif
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic writeProto(input int unsigned addr, input logic [63:0] data);
        ProtoWrEn_SI   = 1'b1;
        ProtoWrAddr_SI = AW'(addr);
        ProtoWrData_DI = data;
        tick();
        ProtoWrEn_SI   = 1'b0;
    endtask

    task automatic acceptQuery(input logic [63:0] m0, input logic [63:0] m1, input logic [63:0] m2);
        HypervectorIn_DI = {m2, m1, m0};
        ValidIn_SI       = 1'b1;
        tick();
        ValidIn_SI       = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int start);
        int n;
        n = start;
        while (ValidOut_SO !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'd17);
    endtask

    task automatic chkResult(input string tag, input int l0, input int d0, input int l1, input int d1);
        chk({tag, "_label0"}, 64'(LabelOut_DO[1:0]),    64'(l0));
        chk({tag, "_dist0"},  64'(DistanceOut_DO[6:0]), 64'(d0));
        chk({tag, "_label1"}, 64'(LabelOut_DO[3:2]),    64'(l1));
        chk({tag, "_dist1"},  64'(DistanceOut_DO[13:7]), 64'(d1));
    endtask

    initial begin
        int seen;

        // Reset values
        tick();
        tick();
        chk("rst_ready", 64'(ReadyOut_SO), 64'd1);
        chk("rst_valid", 64'(ValidOut_SO), 64'd0);
        chkResult("rst", 0, 0, 0, 0);
        Reset_RBI = 1'b1;
        tick();

        // Query A: majority fusion; head0 exact match, head1 distances {64,16,3,6}
        writeProto(0, Q1);
        writeProto(1, Q1 ^ 64'hFF);
        writeProto(2, ~Q1);
        writeProto(3, Q1 ^ 64'hF);
        writeProto(4, ~Q1);
        writeProto(5, Q1 ^ 64'hFFFF);
        writeProto(6, Q1 ^ 64'h0001_0000_0100_0001);
        writeProto(7, Q1 ^ 64'h3F);
        chk("idle_ready", 64'(ReadyOut_SO), 64'd1);
        acceptQuery(64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        chk("search_ready", 64'(ReadyOut_SO), 64'd0);
        waitValid("latency_a", 0);
        chkResult("qa", 0, 0, 2, 3);
`ifdef AM_MARGIN_EN
        chk("qa_margin0", 64'(MarginOut_DO[6:0]),  64'd4);
        chk("qa_margin1", 64'(MarginOut_DO[13:7]), 64'd3);
`endif

        // Backpressure: outputs hold while ReadyIn_SI is low
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(ValidOut_SO), 64'd1);
            chk("stall_dist1", 64'(DistanceOut_DO[13:7]), 64'd3);
        end
        ReadyIn_SI = 1'b1;
        tick();
        ReadyIn_SI = 1'b0;
        chk("hs_valid_low", 64'(ValidOut_SO), 64'd0);
        chk("hs_ready_high", 64'(ReadyOut_SO), 64'd1);
        chkResult("hold_after_hs", 0, 0, 2, 3);

        // Query B: tie {9,3,3,40} on head0, {9,3,5,40} on head1; write with accept and during search are dropped
        writeProto(0, Q2 ^ 64'h1FF);
        writeProto(1, Q2 ^ 64'h0000_0001_0001_0001);
        writeProto(2, Q2 ^ 64'hE000_0000_0000_0000);
        writeProto(3, Q2 ^ M40);
        writeProto(4, Q2 ^ 64'h1FF);
        writeProto(5, Q2 ^ 64'h7);
        writeProto(6, Q2 ^ 64'h1F);
        writeProto(7, Q2 ^ M40);
        ProtoWrEn_SI   = 1'b1;
        ProtoWrAddr_SI = AW'(0);
        ProtoWrData_DI = Q2;
        acceptQuery(Q2, Q2, Q2);
        ProtoWrAddr_SI = AW'(3);
        tick();
        ProtoWrEn_SI   = 1'b0;
        waitValid("latency_b", 1);
        chkResult("qb", 1, 3, 1, 3);
`ifdef AM_MARGIN_EN
        chk("qb_margin0", 64'(MarginOut_DO[6:0]),  64'd0);
        chk("qb_margin1", 64'(MarginOut_DO[13:7]), 64'd2);
`endif
        ReadyIn_SI = 1'b1;
        tick();

        // Query C: same query again, must still see the old prototypes
        acceptQuery(Q2, Q2, Q2);
        waitValid("latency_c", 0);
        chkResult("qc", 1, 3, 1, 3);
        tick();
        chk("qc_valid_drop", 64'(ValidOut_SO), 64'd0);
        ReadyIn_SI = 1'b0;

        // Reset mid-search aborts and clears everything
        acceptQuery(Q1, Q1, Q1);
        for (int i = 0; i < 5; i++) tick();
        Reset_RBI = 1'b0;
        #1;
        chk("abort_ready", 64'(ReadyOut_SO), 64'd1);
        chk("abort_valid", 64'(ValidOut_SO), 64'd0);
        chkResult("abort", 0, 0, 0, 0);
        tick();
        Reset_RBI = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ValidOut_SO === 1'b1) seen = 1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);

        // Cleared prototypes: every class ties at popcount(Q2)=32, label 0 wins
        ReadyIn_SI = 1'b1;
        acceptQuery(Q2, Q2, Q2);
        waitValid("latency_d", 0);
        chkResult("qd", 0, 32, 0, 32);
`ifdef AM_MARGIN_EN
        chk("qd_margin0", 64'(MarginOut_DO[6:0]), 64'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
